// File: rtl/ldst_unit.sv
// ldst_unit: ARM7 single data transfer unit (byte/half/word, signed loads, shifted offsets, bus handshake with timeout)
module ldst_unit #(
    parameter int RF_RD_LAT   = 2,
    parameter int TIMEOUT     = 16,
    parameter int ALIGN_ABORT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        immediate,
    input  logic        pre,
    input  logic        up,
    input  logic [1:0]  size,
    input  logic        signed_ld,
    input  logic        write,
    input  logic        load,
    input  logic [3:0]  rn,
    input  logic [3:0]  rd,
    input  logic [11:0] offset,
    input  logic        carry_in,
    output logic        busy,
    output logic        done,
    output logic        abort,
    output logic        rf_rd_en,
    output logic [3:0]  rf_rd_reg,
    input  logic [31:0] rf_rd_value,
    output logic        rf_wr_en,
    output logic [3:0]  rf_wr_reg,
    output logic [31:0] rf_wr_value,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);
    typedef enum logic [3:0] {IDLE, RD_RN, RD_RM, ADDR, RD_RD, MEM, WB_BASE, WB_LD, DONE} state_t;
    localparam int CMAX = RF_RD_LAT > TIMEOUT ? RF_RD_LAT : TIMEOUT;
    localparam int CW = $clog2(CMAX + 1);
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic abort_q, abort_n;
    logic imm_q, pre_q, up_q, sgn_q, wr_q, ld_q, c_q;
    logic [1:0] size_q;
    logic [3:0] rn_q, rd_q;
    logic [11:0] off_q;
    logic [31:0] base_q, rm_q, rdv_q, eff_q, addr_q, rdata_q;
    logic word, half, mis, lat_hit;
    logic [4:0] sh;
    logic [5:0] sa;
    logic [31:0] shifted, off_val, eff_c, a_c, bus_addr, rotw, ld_val, wdata;
    logic [3:0] be;
    logic [7:0] b8;
    logic [15:0] h16;
    always_comb begin
        word = size_q[1];
        half = size_q == 2'd1;
        sh = off_q[11:7];
        shifted = off_q[6:5] == 2'd0 ? rm_q << sh :
                  off_q[6:5] == 2'd1 ? (sh == 5'd0 ? 32'd0 : rm_q >> sh) :
                  off_q[6:5] == 2'd2 ? (sh == 5'd0 ? {32{rm_q[31]}} : 32'($signed(rm_q) >>> sh)) :
                  (sh == 5'd0 ? {c_q, rm_q[31:1]} : (rm_q >> sh) | (rm_q << (6'd32 - {1'b0, sh})));
        off_val = imm_q ? {20'd0, off_q} : shifted;
        eff_c = up_q ? base_q + off_val : base_q - off_val;
        a_c = pre_q ? eff_c : base_q;
        mis = half ? a_c[0] : word & (|a_c[1:0]);
        bus_addr = ALIGN_ABORT != 0 ? addr_q : word ? {addr_q[31:2], 2'b00} :
                   half ? {addr_q[31:1], 1'b0} : addr_q;
        be = word ? 4'b1111 : half ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b0001 << addr_q[1:0];
        wdata = word ? rdv_q : half ? {2{rdv_q[15:0]}} : {4{rdv_q[7:0]}};
        sa = {1'b0, addr_q[1:0], 3'b000};
        rotw = (rdata_q >> sa) | (rdata_q << (6'd32 - sa));
        b8 = 8'(rdata_q >> sa);
        h16 = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        ld_val = word ? rotw : half ? {{16{sgn_q & h16[15]}}, h16} : {{24{sgn_q & b8[7]}}, b8};
        lat_hit = cnt == CW'(RF_RD_LAT);
    end
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        abort_n = abort_q;
        busy = !(state inside {IDLE, DONE});
        done = 1'b0;
        abort = 1'b0;
        rf_rd_en = 1'b0;
        rf_rd_reg = 4'd0;
        rf_wr_en = 1'b0;
        rf_wr_reg = 4'd0;
        rf_wr_value = 32'd0;
        mem_req = 1'b0;
        mem_we = 1'b0;
        mem_addr = 32'd0;
        mem_be = 4'd0;
        mem_wdata = 32'd0;
        case (state)
            IDLE: if (en) begin
                state_n = RD_RN;
                cnt_n = '0;
                abort_n = 1'b0;
            end
            RD_RN, RD_RM, RD_RD: begin
                rf_rd_en = cnt == '0;
                rf_rd_reg = !rf_rd_en ? 4'd0 : state == RD_RN ? rn_q : state == RD_RM ? off_q[3:0] : rd_q;
                cnt_n = lat_hit ? '0 : cnt + CW'(1);
                if (lat_hit)
                    state_n = state == RD_RN ? (imm_q ? ADDR : RD_RM) : state == RD_RM ? ADDR : MEM;
            end
            ADDR: if (ALIGN_ABORT != 0 && mis) begin
                abort_n = 1'b1;
                state_n = DONE;
            end else state_n = ld_q ? MEM : RD_RD;
            MEM: begin
                mem_req = 1'b1;
                mem_we = !ld_q;
                mem_addr = bus_addr;
                mem_be = be;
                mem_wdata = ld_q ? 32'd0 : wdata;
                if (mem_ack) begin
                    cnt_n = '0;
                    state_n = (wr_q || !pre_q) ? WB_BASE : ld_q ? WB_LD : DONE;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    cnt_n = '0;
                    abort_n = 1'b1;
                    state_n = DONE;
                end else cnt_n = cnt + CW'(1);
            end
            WB_BASE: begin
                rf_wr_en = 1'b1;
                rf_wr_reg = rn_q;
                rf_wr_value = eff_q;
                state_n = ld_q ? WB_LD : DONE;
            end
            WB_LD: begin
                rf_wr_en = 1'b1;
                rf_wr_reg = rd_q;
                rf_wr_value = ld_val;
                state_n = DONE;
            end
            DONE: begin
                done = 1'b1;
                abort = abort_q;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            abort_q <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            abort_q <= abort_n;
        end
    end
    always_ff @(posedge clk) begin
        if (state == IDLE && en) begin
            {imm_q, pre_q, up_q, sgn_q, wr_q, ld_q, c_q} <= {immediate, pre, up, signed_ld, write, load, carry_in};
            size_q <= size;
            rn_q <= rn;
            rd_q <= rd;
            off_q <= offset;
        end
        if (lat_hit && state == RD_RN) base_q <= rf_rd_value;
        if (lat_hit && state == RD_RM) rm_q <= rf_rd_value;
        if (lat_hit && state == RD_RD) rdv_q <= rf_rd_value;
        if (state == ADDR) begin
            eff_q <= eff_c;
            addr_q <= a_c;
        end
        if (state == MEM && mem_ack) rdata_q <= mem_rdata;
    end
endmodule

// File: tb/tb_ldst_unit.sv
// tb_ldst_unit: directed bench for ldst_unit, aborting (u0) and rotating (u1) alignment variants side by side
module tb_ldst_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst, en, immediate, pre, up, signed_ld, write, load, carry_in;
    logic [1:0] size;
    logic [3:0] rn, rd;
    logic [11:0] offset;
    logic busy[2], done[2], abort[2], rf_rd_en[2], rf_wr_en[2], mem_req[2], mem_we[2], mem_ack[2];
    logic [3:0] rf_rd_reg[2], rf_wr_reg[2], mem_be[2];
    logic [31:0] rf_rd_value[2], rf_wr_value[2], mem_addr[2], mem_wdata[2], mem_rdata[2];
    logic [31:0] rf[2][16];
    logic [31:0] mem[1024];
    logic [3:0] p0[2], p1[2];
    int nwr[2], nreq[2], ndone[2], rq[2];
    logic last_abort[2], unst[2], hold[2], l_we[2];
    logic [68:0] pv[2];
    logic [31:0] l_addr[2], l_wd[2];
    logic [3:0] l_be[2];
    logic [114:0] outv[2];
    logic ack_en, clr, set_en, mset_en;
    int ack_dly;
    logic [3:0] set_reg;
    logic [31:0] set_val, mset_val;
    logic [9:0] mset_idx;
    int pass = 0, total = 0;

    ldst_unit #(.RF_RD_LAT(2), .TIMEOUT(16), .ALIGN_ABORT(1)) u0 (
        .clk(clk), .rst(rst), .en(en), .immediate(immediate), .pre(pre), .up(up), .size(size),
        .signed_ld(signed_ld), .write(write), .load(load), .rn(rn), .rd(rd), .offset(offset),
        .carry_in(carry_in), .busy(busy[0]), .done(done[0]), .abort(abort[0]),
        .rf_rd_en(rf_rd_en[0]), .rf_rd_reg(rf_rd_reg[0]), .rf_rd_value(rf_rd_value[0]),
        .rf_wr_en(rf_wr_en[0]), .rf_wr_reg(rf_wr_reg[0]), .rf_wr_value(rf_wr_value[0]),
        .mem_req(mem_req[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_be(mem_be[0]),
        .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .mem_ack(mem_ack[0]));
    ldst_unit #(.RF_RD_LAT(2), .TIMEOUT(16), .ALIGN_ABORT(0)) u1 (
        .clk(clk), .rst(rst), .en(en), .immediate(immediate), .pre(pre), .up(up), .size(size),
        .signed_ld(signed_ld), .write(write), .load(load), .rn(rn), .rd(rd), .offset(offset),
        .carry_in(carry_in), .busy(busy[1]), .done(done[1]), .abort(abort[1]),
        .rf_rd_en(rf_rd_en[1]), .rf_rd_reg(rf_rd_reg[1]), .rf_rd_value(rf_rd_value[1]),
        .rf_wr_en(rf_wr_en[1]), .rf_wr_reg(rf_wr_reg[1]), .rf_wr_value(rf_wr_value[1]),
        .mem_req(mem_req[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_be(mem_be[1]),
        .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .mem_ack(mem_ack[1]));

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w, input logic [3:0] b);
        for (int k = 0; k < 4; k++) if (b[k]) o[8*k +: 8] = w[8*k +: 8];
        return o;
    endfunction

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            rf_rd_value[i] = rf[i][p1[i]];
            mem_rdata[i] = mem[mem_addr[i][11:2]];
            mem_ack[i] = mem_req[i] && ack_en && rq[i] >= ack_dly;
            outv[i] = {busy[i], done[i], abort[i], rf_rd_en[i], rf_rd_reg[i], rf_wr_en[i], rf_wr_reg[i],
                       rf_wr_value[i], mem_req[i], mem_we[i], mem_addr[i], mem_be[i], mem_wdata[i]};
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            p0[i] <= rf_rd_reg[i];
            p1[i] <= p0[i];
            if (rf_wr_en[i]) begin
                rf[i][rf_wr_reg[i]] <= rf_wr_value[i];
                nwr[i] <= nwr[i] + 1;
            end
            if (mem_req[i]) nreq[i] <= nreq[i] + 1;
            rq[i] <= (mem_req[i] && !mem_ack[i]) ? rq[i] + 1 : 0;
            if (done[i]) begin
                ndone[i] <= ndone[i] + 1;
                last_abort[i] <= abort[i];
            end
            if (mem_req[i] && mem_ack[i]) begin
                l_addr[i] <= mem_addr[i];
                l_be[i] <= mem_be[i];
                l_wd[i] <= mem_wdata[i];
                l_we[i] <= mem_we[i];
                if (mem_we[i]) mem[mem_addr[i][11:2]] <= merge(mem[mem_addr[i][11:2]], mem_wdata[i], mem_be[i]);
            end
            if (hold[i] && pv[i] !== {mem_we[i], mem_addr[i], mem_be[i], mem_wdata[i]}) unst[i] <= 1'b1;
            hold[i] <= mem_req[i] && !mem_ack[i];
            pv[i] <= {mem_we[i], mem_addr[i], mem_be[i], mem_wdata[i]};
            if (set_en) rf[i][set_reg] <= set_val;
            if (clr) begin
                nwr[i] <= 0;
                nreq[i] <= 0;
                ndone[i] <= 0;
                unst[i] <= 1'b0;
                last_abort[i] <= 1'b0;
            end
        end
        if (mset_en) mem[mset_idx] <= mset_val;
    end

    task automatic set_r(input logic [3:0] r, input logic [31:0] v);
        @(negedge clk);
        set_en = 1'b1; set_reg = r; set_val = v;
        @(negedge clk);
        set_en = 1'b0;
    endtask

    task automatic set_m(input logic [31:0] a, input logic [31:0] v);
        @(negedge clk);
        mset_en = 1'b1; mset_idx = a[11:2]; mset_val = v;
        @(negedge clk);
        mset_en = 1'b0;
    endtask

    task automatic start(input logic imm, input logic p, input logic u, input logic s, input logic w,
                         input logic l, input logic [1:0] sz, input logic [3:0] n, input logic [3:0] d,
                         input logic [11:0] off, input logic c);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        immediate = imm; pre = p; up = u; signed_ld = s; write = w; load = l;
        size = sz; rn = n; rd = d; offset = off; carry_in = c; en = 1'b1;
        @(negedge clk);
        en = 1'b0;
    endtask

    task automatic wait_done();
        int cyc = 0;
        while ((ndone[0] == 0 || ndone[1] == 0) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        total++;
        if (cyc >= 100) $display("FAIL done_wait got=%0d/%0d dones exp=1/1", ndone[0], ndone[1]);
        else pass++;
    endtask

    task automatic run(input logic imm, input logic p, input logic u, input logic s, input logic w,
                       input logic l, input logic [1:0] sz, input logic [3:0] n, input logic [3:0] d,
                       input logic [11:0] off, input logic c);
        start(imm, p, u, s, w, l, sz, n, d, off, c);
        wait_done();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            total++;
            if (outv[i] !== '0) $display("FAIL reset_outputs[%0d] got=%h exp=0", i, outv[i]);
            else pass++;
        end
        rst = 1'b0;
    endtask

    task automatic test_ldr_imm();
        set_r(1, 32'h100); set_r(2, 32'h0); set_m(32'h104, 32'hDEADBEEF);
        run(1, 1, 1, 0, 1, 1, 2'd2, 4'd1, 4'd2, 12'd4, 0);
        total++; if (rf[0][2] !== 32'hDEADBEEF) $display("FAIL ldr_rd got=%h exp=deadbeef", rf[0][2]); else pass++;
        total++; if (rf[0][1] !== 32'h104) $display("FAIL ldr_wb got=%h exp=104", rf[0][1]); else pass++;
        total++; if (last_abort[0] !== 1'b0) $display("FAIL ldr_abort got=%b exp=0", last_abort[0]); else pass++;
        total++; if (nwr[0] !== 2) $display("FAIL ldr_nwr got=%0d exp=2", nwr[0]); else pass++;
        total++; if (l_addr[0] !== 32'h104 || l_we[0] !== 1'b0) $display("FAIL ldr_bus got=%h/%b exp=104/0", l_addr[0], l_we[0]); else pass++;
        total++; if (rf[1][2] !== 32'hDEADBEEF) $display("FAIL ldr_rd_u1 got=%h exp=deadbeef", rf[1][2]); else pass++;
    endtask

    task automatic test_strb_post();
        set_r(1, 32'h203); set_r(2, 32'h12345678); set_m(32'h200, 32'h0);
        ack_dly = 2;
        run(1, 0, 1, 0, 0, 0, 2'd0, 4'd1, 4'd2, 12'd5, 0);
        ack_dly = 0;
        total++; if (l_be[0] !== 4'b1000) $display("FAIL strb_be got=%b exp=1000", l_be[0]); else pass++;
        total++; if (l_wd[0] !== 32'h78787878) $display("FAIL strb_wdata got=%h exp=78787878", l_wd[0]); else pass++;
        total++; if (l_addr[0] !== 32'h203 || l_we[0] !== 1'b1) $display("FAIL strb_bus got=%h/%b exp=203/1", l_addr[0], l_we[0]); else pass++;
        total++; if (rf[0][1] !== 32'h208) $display("FAIL strb_wb got=%h exp=208", rf[0][1]); else pass++;
        total++; if (mem[128] !== 32'h78000000) $display("FAIL strb_mem got=%h exp=78000000", mem[128]); else pass++;
        total++; if (unst[0] !== 1'b0) $display("FAIL strb_stable got=%b exp=0", unst[0]); else pass++;
        total++; if (nwr[0] !== 1) $display("FAIL strb_nwr got=%0d exp=1", nwr[0]); else pass++;
    endtask

    task automatic test_half_byte_loads();
        set_r(3, 32'h300); set_r(4, 32'h2); set_r(5, 32'h0); set_m(32'h304, 32'h12348001);
        run(0, 1, 1, 1, 0, 1, 2'd1, 4'd3, 4'd5, 12'h084, 0);
        total++; if (rf[0][5] !== 32'hFFFF8001) $display("FAIL ldrsh_rd got=%h exp=ffff8001", rf[0][5]); else pass++;
        total++; if (rf[0][3] !== 32'h300 || nwr[0] !== 1) $display("FAIL ldrsh_base got=%h/%0d exp=300/1", rf[0][3], nwr[0]); else pass++;
        run(1, 1, 1, 1, 0, 1, 2'd0, 4'd3, 4'd5, 12'd5, 0);
        total++; if (rf[0][5] !== 32'hFFFFFF80) $display("FAIL ldrsb_rd got=%h exp=ffffff80", rf[0][5]); else pass++;
        run(1, 1, 1, 0, 0, 1, 2'd1, 4'd3, 4'd5, 12'd6, 0);
        total++; if (rf[0][5] !== 32'h00001234) $display("FAIL ldrh_hi got=%h exp=00001234", rf[0][5]); else pass++;
    endtask

    task automatic test_misaligned();
        set_r(1, 32'h100); set_r(6, 32'hCAFEF00D); set_m(32'h100, 32'h11223344);
        run(1, 1, 1, 0, 0, 1, 2'd2, 4'd1, 4'd6, 12'd1, 0);
        total++; if (nreq[0] !== 0) $display("FAIL mis_noreq got=%0d exp=0", nreq[0]); else pass++;
        total++; if (last_abort[0] !== 1'b1) $display("FAIL mis_abort got=%b exp=1", last_abort[0]); else pass++;
        total++; if (nwr[0] !== 0 || rf[0][6] !== 32'hCAFEF00D) $display("FAIL mis_nowr got=%0d/%h exp=0/cafef00d", nwr[0], rf[0][6]); else pass++;
        total++; if (rf[1][6] !== 32'h44112233) $display("FAIL mis_rot got=%h exp=44112233", rf[1][6]); else pass++;
        total++; if (l_addr[1] !== 32'h100 || last_abort[1] !== 1'b0) $display("FAIL mis_u1_bus got=%h/%b exp=100/0", l_addr[1], last_abort[1]); else pass++;
    endtask

    task automatic test_timeout();
        set_r(1, 32'h100);
        ack_en = 1'b0;
        run(1, 1, 1, 0, 1, 1, 2'd2, 4'd1, 4'd3, 12'd0, 0);
        total++; if (nreq[0] !== 16) $display("FAIL to_req_cycles got=%0d exp=16", nreq[0]); else pass++;
        total++; if (last_abort[0] !== 1'b1) $display("FAIL to_abort got=%b exp=1", last_abort[0]); else pass++;
        total++; if (nwr[0] !== 0) $display("FAIL to_nowr got=%0d exp=0", nwr[0]); else pass++;
        total++; if (mem_req[0] !== 1'b0) $display("FAIL to_req_low got=%b exp=0", mem_req[0]); else pass++;
        ack_en = 1'b1;
    endtask

    task automatic test_asr_ror();
        set_r(1, 32'h100); set_r(7, 32'h80000000); set_r(8, 32'h0);
        run(0, 1, 0, 0, 1, 1, 2'd0, 4'd1, 4'd8, 12'h047, 0);
        total++; if (rf[0][8] !== 32'h33) $display("FAIL asr0_rd got=%h exp=33", rf[0][8]); else pass++;
        total++; if (rf[0][1] !== 32'h101) $display("FAIL asr0_wb got=%h exp=101", rf[0][1]); else pass++;
        set_r(7, 32'h10); set_r(9, 32'h80000108); set_r(10, 32'h0);
        run(0, 1, 0, 0, 1, 1, 2'd2, 4'd9, 4'd10, 12'h067, 1);
        total++; if (rf[0][10] !== 32'h11223344) $display("FAIL rrx_rd got=%h exp=11223344", rf[0][10]); else pass++;
        total++; if (rf[0][9] !== 32'h100) $display("FAIL rrx_wb got=%h exp=100", rf[0][9]); else pass++;
    endtask

    task automatic test_rd_eq_rn();
        set_r(11, 32'h100);
        run(1, 0, 1, 0, 0, 1, 2'd2, 4'd11, 4'd11, 12'd8, 0);
        total++; if (rf[0][11] !== 32'h11223344) $display("FAIL rdrn_final got=%h exp=11223344", rf[0][11]); else pass++;
        total++; if (nwr[0] !== 2) $display("FAIL rdrn_nwr got=%0d exp=2", nwr[0]); else pass++;
    endtask

    task automatic test_busy_ignore();
        int cyc = 0;
        set_r(1, 32'h100); set_r(12, 32'h0); set_r(13, 32'h0);
        start(1, 1, 1, 0, 0, 1, 2'd2, 4'd1, 4'd12, 12'd0, 0);
        total++; if (busy[0] !== 1'b1) $display("FAIL busy_high got=%b exp=1", busy[0]); else pass++;
        rd = 4'd13; offset = 12'd4; en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        wait_done();
        repeat (5) @(negedge clk);
        total++; if (ndone[0] !== 1) $display("FAIL busy_one_done got=%0d exp=1", ndone[0]); else pass++;
        total++; if (rf[0][12] !== 32'h11223344 || rf[0][13] !== 32'h0) $display("FAIL busy_regs got=%h/%h exp=11223344/0", rf[0][12], rf[0][13]); else pass++;
        while (cyc < 50 && !mem_req[0]) begin
            @(negedge clk);
            cyc++;
        end
        total++; if (mem_req[0] !== 1'b0) $display("FAIL busy_idle_req got=%b exp=0", mem_req[0]); else pass++;
    endtask

    task automatic test_rst_mid_mem();
        int cyc = 0;
        set_r(1, 32'h100);
        ack_en = 1'b0;
        start(1, 1, 1, 0, 1, 0, 2'd2, 4'd1, 4'd2, 12'd0, 0);
        while (!mem_req[0] && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        total++; if (mem_req[0] !== 1'b1) $display("FAIL rst_reach_mem got=%b exp=1", mem_req[0]); else pass++;
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            total++;
            if (outv[i] !== '0) $display("FAIL rst_mid_outputs[%0d] got=%h exp=0", i, outv[i]);
            else pass++;
        end
        total++; if (nwr[0] !== 0 || rf[0][1] !== 32'h100) $display("FAIL rst_mid_nowr got=%0d/%h exp=0/100", nwr[0], rf[0][1]); else pass++;
        rst = 1'b0;
        ack_en = 1'b1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; immediate = 1'b0; pre = 1'b0; up = 1'b0; signed_ld = 1'b0;
        write = 1'b0; load = 1'b0; carry_in = 1'b0; size = 2'd0; rn = 4'd0; rd = 4'd0; offset = 12'd0;
        ack_en = 1'b1; ack_dly = 0; clr = 1'b0; set_en = 1'b0; mset_en = 1'b0;
        set_reg = 4'd0; set_val = 32'd0; mset_idx = 10'd0; mset_val = 32'd0;
        test_reset();
        test_ldr_imm();
        test_strb_post();
        test_half_byte_loads();
        test_misaligned();
        test_timeout();
        test_asr_ror();
        test_rd_eq_rn();
        test_busy_ignore();
        test_rst_mid_mem();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
